// File: rtl/reg_permute_map_if.sv
// Decode-side bundle for the register remapper: index/op inputs and mapped/checkpoint outputs.
interface reg_permute_map_if #(
  parameter int NUM_REGS   = 8,
  parameter int CKPT_DEPTH = 4
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);

  logic [IDX_W-1:0] reg1;
  logic [IDX_W-1:0] reg2;
  logic [IDX_W-1:0] reg_write;
  logic [2:0]       op;
  logic [IDX_W-1:0] reg1_mapped;
  logic [IDX_W-1:0] reg2_mapped;
  logic [IDX_W-1:0] reg0_mapped;
  logic [IDX_W-1:0] reg_write_mapped;
  logic [CNT_W-1:0] ckpt_count;
  logic             ckpt_full;
  logic             ckpt_empty;
  logic             op_err;

  modport master (
    output reg1, reg2, reg_write, op,
    input  reg1_mapped, reg2_mapped, reg0_mapped, reg_write_mapped,
    input  ckpt_count, ckpt_full, ckpt_empty, op_err
  );

  modport slave (
    input  reg1, reg2, reg_write, op,
    output reg1_mapped, reg2_mapped, reg0_mapped, reg_write_mapped,
    output ckpt_count, ckpt_full, ckpt_empty, op_err
  );
endinterface

// File: rtl/reg_permute_map.sv
// Logical-to-physical register remapper with swap/rotate/identity ops and a checkpoint stack.
// Lookups are combinational on the registered map; ops commit in one cycle, never stall.
module reg_permute_map #(
  parameter int NUM_REGS   = 8,
  parameter int CKPT_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  reg_permute_map_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(CKPT_DEPTH + 1);
  localparam int SLOT_W = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;

  localparam logic [2:0] OP_SWAP  = 3'b001;
  localparam logic [2:0] OP_ROTL  = 3'b010;
  localparam logic [2:0] OP_IDENT = 3'b011;
  localparam logic [2:0] OP_PUSH  = 3'b100;
  localparam logic [2:0] OP_POP   = 3'b101;

  logic [IDX_W-1:0]  map_q   [NUM_REGS];
  logic [IDX_W-1:0]  map_d   [NUM_REGS];
  logic [IDX_W-1:0]  stack_q [CKPT_DEPTH][NUM_REGS];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              push_en;
  logic              full, empty;
  logic [CNT_W-1:0]  cnt_m1;
  logic [SLOT_W-1:0] push_slot, pop_slot;

  assign full      = (cnt_q == CNT_W'(CKPT_DEPTH));
  assign empty     = (cnt_q == '0);
  assign cnt_m1    = cnt_q - CNT_W'(1);
  assign push_slot = cnt_q[SLOT_W-1:0];
  assign pop_slot  = cnt_m1[SLOT_W-1:0];

  always_comb begin
    map_d   = map_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    push_en = 1'b0;
    case (bus.op)
      // Equal operands read and write the same entry, so the map is naturally unchanged.
      OP_SWAP: begin
        map_d[bus.reg1] = map_q[bus.reg2];
        map_d[bus.reg2] = map_q[bus.reg1];
      end
      OP_ROTL: begin
        for (int i = 0; i < NUM_REGS; i++) map_d[i] = map_q[IDX_W'(i + 1)];
      end
      OP_IDENT: begin
        for (int i = 0; i < NUM_REGS; i++) map_d[i] = IDX_W'(i);
      end
      OP_PUSH: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          push_en = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          map_d = stack_q[pop_slot];
          cnt_d = cnt_m1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) map_q[i] <= IDX_W'(i);
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack storage needs no reset: entries at or above the count are never read.
  always_ff @(posedge clk) begin
    if (push_en && !reset) stack_q[push_slot] <= map_q;
  end

  assign bus.reg1_mapped      = map_q[bus.reg1];
  assign bus.reg2_mapped      = map_q[bus.reg2];
  assign bus.reg0_mapped      = map_q[0];
  assign bus.reg_write_mapped = map_q[bus.reg_write];
  assign bus.ckpt_count       = cnt_q;
  assign bus.ckpt_full        = full;
  assign bus.ckpt_empty       = empty;
  assign bus.op_err           = err_q;
endmodule
